// File: rtl/cpu_dbg_pkg.sv
// ============================================================================
// Module      : cpu_dbg_pkg
// Description : Shared types and constants for the CPU debug execution control.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        RST_HOLD_S = 2'd0,
        PAUSED     = 2'd1,
        RUN        = 2'd2
    } state_t;

    localparam int c_speed_w = 2;
    typedef logic [c_speed_w-1:0] speed_t;

    localparam speed_t c_speed_fast = 2'd0;
    localparam speed_t c_speed_slow = 2'd3;

    // Also consumed by the seven-segment display mux.
    localparam int c_cyc_w = 16;

    function automatic speed_t speed_advance(input speed_t s);
        return (s == c_speed_slow) ? c_speed_fast : speed_t'(s + 1'b1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_tick_gen.sv
// ============================================================================
// Module      : cpu_tick_gen
// Description : Run-mode period counter; one-cycle tick every DIV_BASE<<(2*speed) cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpu_tick_gen
    import cpu_dbg_pkg::*;
#(
    parameter int CNT_W    = 27,
    parameter int DIV_BASE = 1_562_500
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  logic   enable,
    input  speed_t speed_sel,
    output logic   tick
);

    generate
        if ((DIV_BASE < 1) || ((longint'(DIV_BASE) << 6) > (longint'(1) << CNT_W))) begin : g_width_err
            $error("cpu_tick_gen: DIV_BASE<<6 must be between 1 and 2**CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] c_last_0 = CNT_W'((longint'(DIV_BASE) << 0) - 1);
    localparam logic [CNT_W-1:0] c_last_1 = CNT_W'((longint'(DIV_BASE) << 2) - 1);
    localparam logic [CNT_W-1:0] c_last_2 = CNT_W'((longint'(DIV_BASE) << 4) - 1);
    localparam logic [CNT_W-1:0] c_last_3 = CNT_W'((longint'(DIV_BASE) << 6) - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last;
    logic             w_at_last;

    always_comb begin
        w_last = c_last_3;
        case (speed_sel)
            2'd0:    w_last = c_last_0;
            2'd1:    w_last = c_last_1;
            2'd2:    w_last = c_last_2;
            default: w_last = c_last_3;
        endcase
    end

    assign w_at_last = (r_cnt == w_last);

    // A clear in the same cycle as the terminal count swallows that tick.
    assign tick = enable && !clear && w_at_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
// ============================================================================
// Module      : cpu_step_ctrl
// Description : Debug controller: single-step, free-run, pause and reset of the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpu_step_ctrl
    import cpu_dbg_pkg::*;
#(
    parameter int CNT_W    = 27,
    parameter int DIV_BASE = 1_562_500,
    parameter int RST_HOLD = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               step_p,
    input  logic               run_p,
    input  logic               speed_p,
    input  logic               creset_p,
    input  logic               halt,
    output logic               cpu_en,
    output logic               cpu_rst_n,
    output logic               running,
    output logic [1:0]         speed_sel,
    output logic [c_cyc_w-1:0] cycle_cnt
);

    generate
        if (RST_HOLD < 1) begin : g_hold_err
            $error("cpu_step_ctrl: RST_HOLD must be at least 1");
        end
    endgenerate

    localparam int                c_hold_w    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RST_HOLD - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_hold_w-1:0]  r_hold;
    logic [c_hold_w-1:0]  w_hold_nxt;
    logic                 r_cpu_en;
    logic                 w_en_nxt;
    logic                 r_cpu_rst_n;
    logic                 r_running;
    speed_t               r_speed;
    speed_t               w_speed_nxt;
    logic [c_cyc_w-1:0]   r_cycle_cnt;
    logic                 w_tick;
    logic                 w_tick_clear;
    logic                 w_tick_en;

    assign w_tick_en = (r_state == RUN);

    cpu_tick_gen #(
        .CNT_W    (CNT_W),
        .DIV_BASE (DIV_BASE)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .clear     (w_tick_clear),
        .enable    (w_tick_en),
        .speed_sel (r_speed),
        .tick      (w_tick)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold;
        w_en_nxt     = 1'b0;
        w_tick_clear = 1'b0;
        w_speed_nxt  = r_speed;

        if (creset_p) begin
            w_state_nxt = RST_HOLD_S;
            w_hold_nxt  = '0;
        end else begin
            if (speed_p && (r_state != RST_HOLD_S)) begin
                w_speed_nxt = speed_advance(r_speed);
                if (r_state == RUN) begin
                    w_tick_clear = 1'b1;
                end
            end

            case (r_state)
                RST_HOLD_S: begin
                    if (r_hold == c_hold_last) begin
                        w_state_nxt = PAUSED;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold + 1'b1;
                    end
                end
                PAUSED: begin
                    // run_p outranks step_p; a halted CPU accepts neither.
                    if (!halt) begin
                        if (run_p) begin
                            w_state_nxt  = RUN;
                            w_tick_clear = 1'b1;
                        end else if (step_p) begin
                            w_en_nxt = 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (run_p || halt) begin
                        w_state_nxt = PAUSED;
                    end else begin
                        w_en_nxt = w_tick;
                    end
                end
                default: begin
                    w_state_nxt = RST_HOLD_S;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RST_HOLD_S;
            r_hold      <= '0;
            r_cpu_en    <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_running   <= 1'b0;
            r_speed     <= c_speed_fast;
        end else begin
            r_state     <= w_state_nxt;
            r_hold      <= w_hold_nxt;
            r_cpu_en    <= w_en_nxt;
            r_cpu_rst_n <= (w_state_nxt != RST_HOLD_S);
            r_running   <= (w_state_nxt == RUN);
            r_speed     <= w_speed_nxt;
        end
    end

    // Counts the enable pulse once its cycle has completed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt <= '0;
        end else if (creset_p) begin
            r_cycle_cnt <= '0;
        end else if (r_cpu_en) begin
            r_cycle_cnt <= r_cycle_cnt + 1'b1;
        end
    end

    assign cpu_en    = r_cpu_en;
    assign cpu_rst_n = r_cpu_rst_n;
    assign running   = r_running;
    assign speed_sel = r_speed;
    assign cycle_cnt = r_cycle_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cpu_step_ctrl.sv
// ============================================================================
// Module      : tb_cpu_step_ctrl
// Description : Self-checking bench for cpu_step_ctrl with an event-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_step_ctrl;

    localparam int CNT_W    = 8;
    localparam int DIV_BASE = 4;
    localparam int RST_HOLD = 3;

    localparam int M_HOLD   = 0;
    localparam int M_PAUSED = 1;
    localparam int M_RUN    = 2;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        step_p   = 1'b0;
    logic        run_p    = 1'b0;
    logic        speed_p  = 1'b0;
    logic        creset_p = 1'b0;
    logic        halt     = 1'b0;
    logic        cpu_en;
    logic        cpu_rst_n;
    logic        running;
    logic [1:0]  speed_sel;
    logic [15:0] cycle_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cpu_step_ctrl #(
        .CNT_W    (CNT_W),
        .DIV_BASE (DIV_BASE),
        .RST_HOLD (RST_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .step_p    (step_p),
        .run_p     (run_p),
        .speed_p   (speed_p),
        .creset_p  (creset_p),
        .halt      (halt),
        .cpu_en    (cpu_en),
        .cpu_rst_n (cpu_rst_n),
        .running   (running),
        .speed_sel (speed_sel),
        .cycle_cnt (cycle_cnt)
    );

    function automatic int period(input logic [1:0] s);
        return DIV_BASE << (2 * s);
    endfunction

    // Reference model: tracks absolute edge numbers for hold release and run firing.
    int          m_mode       = M_HOLD;
    int          m_cyc        = 0;
    int          m_release_at = RST_HOLD;
    int          m_next_fire  = 0;
    logic        exp_en       = 1'b0;
    logic        exp_rst_n    = 1'b0;
    logic        exp_running  = 1'b0;
    logic [1:0]  exp_speed    = 2'd0;
    logic [15:0] exp_cnt      = 16'd0;

    always @(posedge clk or negedge rst) begin
        int         n;
        int         mode;
        int         rel;
        int         fire;
        logic       en;
        logic [1:0] spd;
        if (!rst) begin
            m_mode       <= M_HOLD;
            m_cyc        <= 0;
            m_release_at <= RST_HOLD;
            m_next_fire  <= 0;
            exp_en       <= 1'b0;
            exp_rst_n    <= 1'b0;
            exp_running  <= 1'b0;
            exp_speed    <= 2'd0;
            exp_cnt      <= 16'd0;
        end else begin
            n    = m_cyc + 1;
            mode = m_mode;
            rel  = m_release_at;
            fire = m_next_fire;
            spd  = exp_speed;
            en   = 1'b0;
            if (creset_p) begin
                mode = M_HOLD;
                rel  = n + RST_HOLD;
            end else begin
                if (speed_p && m_mode != M_HOLD) spd = spd + 2'd1;
                if (m_mode == M_HOLD) begin
                    if (n == rel) mode = M_PAUSED;
                end else if (m_mode == M_PAUSED) begin
                    if (!halt && run_p) begin
                        mode = M_RUN;
                        fire = n + period(spd);
                    end else if (!halt && step_p) begin
                        en = 1'b1;
                    end
                end else begin
                    if (run_p || halt) begin
                        mode = M_PAUSED;
                    end else if (speed_p) begin
                        fire = n + period(spd);
                    end else if (n == fire) begin
                        en   = 1'b1;
                        fire = n + period(spd);
                    end
                end
            end
            m_cyc        <= n;
            m_mode       <= mode;
            m_release_at <= rel;
            m_next_fire  <= fire;
            exp_en       <= en;
            exp_rst_n    <= (mode != M_HOLD);
            exp_running  <= (mode == M_RUN);
            exp_speed    <= spd;
            exp_cnt      <= creset_p ? 16'd0 : exp_cnt + (exp_en ? 16'd1 : 16'd0);
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cpu_rst_n !== 1'b0 || cpu_en !== 1'b0 || running !== 1'b0 ||
            cycle_cnt !== 16'd0 || speed_sel !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_values rstn=%b en=%b run=%b cnt=%h spd=%0d (want 0 0 0 0000 0)",
                     cpu_rst_n, cpu_en, running, cycle_cnt, speed_sel);
        end
        rst = 1'b1;
        for (int i = 0; i <= RST_HOLD; i++) begin
            n_checks++;
            if (cpu_rst_n !== (i >= RST_HOLD) || cpu_en !== 1'b0 || running !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_release i=%0d rstn=%b en=%b run=%b (want rstn=%b en=0 run=0)",
                         i, cpu_rst_n, cpu_en, running, (i >= RST_HOLD));
            end
            if (i < RST_HOLD) @(negedge clk);
        end
    endtask

    task automatic test_single_step();
        for (int p = 0; p < 3; p++) begin
            step_p = 1'b1;
            @(negedge clk);
            step_p = 1'b0;
            n_checks++;
            if (cpu_en !== 1'b1 || exp_en !== 1'b1) begin
                n_errors++;
                $display("FAIL step_pulse p=%0d en=%b model=%b (want 1)", p, cpu_en, exp_en);
            end
            for (int j = 1; j < 10; j++) begin
                @(negedge clk);
                n_checks++;
                if (cpu_en !== 1'b0) begin
                    n_errors++;
                    $display("FAIL step_single p=%0d j=%0d en=%b (want 0)", p, j, cpu_en);
                end
            end
        end
        n_checks++;
        if (cycle_cnt !== 16'd3 || exp_cnt !== 16'd3) begin
            n_errors++;
            $display("FAIL step_count cnt=%0d model=%0d (want 3)", cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_run_speed();
        run_p = 1'b1;
        @(negedge clk);
        run_p = 1'b0;
        n_checks++;
        if (running !== 1'b1) begin
            n_errors++;
            $display("FAIL run_enter running=%b (want 1)", running);
        end
        for (int j = 1; j <= 12; j++) begin
            @(negedge clk);
            n_checks++;
            if (cpu_en !== (j % 4 == 0) || cpu_en !== exp_en) begin
                n_errors++;
                $display("FAIL run_p4 j=%0d en=%b model=%b (want %b)", j, cpu_en, exp_en, (j % 4 == 0));
            end
        end
        speed_p = 1'b1;
        @(negedge clk);
        speed_p = 1'b0;
        n_checks++;
        if (speed_sel !== 2'd1 || cpu_en !== 1'b0) begin
            n_errors++;
            $display("FAIL speed_one spd=%0d en=%b (want 1 0)", speed_sel, cpu_en);
        end
        for (int j = 1; j <= 32; j++) begin
            @(negedge clk);
            n_checks++;
            if (cpu_en !== (j % 16 == 0) || cpu_en !== exp_en) begin
                n_errors++;
                $display("FAIL run_p16 j=%0d en=%b model=%b (want %b)", j, cpu_en, exp_en, (j % 16 == 0));
            end
        end
        for (int k = 2; k <= 4; k++) begin
            speed_p = 1'b1;
            @(negedge clk);
            speed_p = 1'b0;
            n_checks++;
            if (speed_sel !== 2'(k % 4) || running !== 1'b1) begin
                n_errors++;
                $display("FAIL speed_wrap k=%0d spd=%0d run=%b (want %0d 1)", k, speed_sel, running, k % 4);
            end
        end
        run_p = 1'b1;
        @(negedge clk);
        run_p = 1'b0;
        for (int j = 0; j < 20; j++) begin
            n_checks++;
            if (cpu_en !== 1'b0 || running !== 1'b0) begin
                n_errors++;
                $display("FAIL run_pause j=%0d en=%b run=%b (want 0 0)", j, cpu_en, running);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        run_p = 1'b1;
        @(negedge clk);
        run_p = 1'b0;
        repeat (6) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        n_checks++;
        if (running !== 1'b0 || cpu_en !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_pause run=%b en=%b (want 0 0)", running, cpu_en);
        end
        for (int j = 0; j < 20; j++) begin
            step_p = (j % 5 == 1);
            run_p  = (j % 5 == 3);
            @(negedge clk);
            step_p = 1'b0;
            run_p  = 1'b0;
            n_checks++;
            if (cpu_en !== 1'b0 || running !== 1'b0) begin
                n_errors++;
                $display("FAIL halt_ignore j=%0d en=%b run=%b (want 0 0)", j, cpu_en, running);
            end
        end
        halt     = 1'b0;
        creset_p = 1'b1;
        @(negedge clk);
        creset_p = 1'b0;
        n_checks++;
        if (cycle_cnt !== 16'd0 || cpu_rst_n !== 1'b0) begin
            n_errors++;
            $display("FAIL creset_clear cnt=%h rstn=%b (want 0000 0)", cycle_cnt, cpu_rst_n);
        end
        for (int i = 1; i <= RST_HOLD; i++) begin
            @(negedge clk);
            n_checks++;
            if (cpu_rst_n !== (i >= RST_HOLD) || cpu_en !== 1'b0) begin
                n_errors++;
                $display("FAIL creset_hold i=%0d rstn=%b en=%b (want %b 0)", i, cpu_rst_n, cpu_en, (i >= RST_HOLD));
            end
        end
    endtask

    task automatic test_priority();
        logic [1:0] saved;
        saved    = speed_sel;
        creset_p = 1'b1;
        run_p    = 1'b1;
        step_p   = 1'b1;
        speed_p  = 1'b1;
        @(negedge clk);
        {creset_p, run_p, step_p, speed_p} = 4'b0000;
        n_checks++;
        if (cpu_rst_n !== 1'b0 || running !== 1'b0 || cpu_en !== 1'b0 || speed_sel !== saved) begin
            n_errors++;
            $display("FAIL prio_creset rstn=%b run=%b en=%b spd=%0d (want 0 0 0 %0d)",
                     cpu_rst_n, running, cpu_en, speed_sel, saved);
        end
        for (int i = 1; i <= RST_HOLD; i++) begin
            speed_p = (i == 1);
            step_p  = (i == 1);
            @(negedge clk);
            speed_p = 1'b0;
            step_p  = 1'b0;
            n_checks++;
            if (cpu_en !== 1'b0 || speed_sel !== saved || cpu_rst_n !== (i >= RST_HOLD)) begin
                n_errors++;
                $display("FAIL prio_hold i=%0d en=%b spd=%0d rstn=%b (want 0 %0d %b)",
                         i, cpu_en, speed_sel, cpu_rst_n, saved, (i >= RST_HOLD));
            end
        end
        run_p  = 1'b1;
        step_p = 1'b1;
        @(negedge clk);
        run_p  = 1'b0;
        step_p = 1'b0;
        n_checks++;
        if (running !== 1'b1 || cpu_en !== 1'b0) begin
            n_errors++;
            $display("FAIL prio_run_step run=%b en=%b (want 1 0)", running, cpu_en);
        end
        for (int j = 1; j <= period(saved); j++) begin
            @(negedge clk);
            n_checks++;
            if (cpu_en !== (j == period(saved))) begin
                n_errors++;
                $display("FAIL prio_first_tick j=%0d en=%b (want %b)", j, cpu_en, (j == period(saved)));
            end
        end
        run_p = 1'b1;
        @(negedge clk);
        run_p = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            step_p   = ($urandom_range(0, 7) == 0);
            run_p    = ($urandom_range(0, 15) == 0);
            speed_p  = ($urandom_range(0, 31) == 0);
            creset_p = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 63) == 0) halt = ~halt;
            @(negedge clk);
            n_checks++;
            if (cpu_en !== exp_en || cpu_rst_n !== exp_rst_n || running !== exp_running ||
                speed_sel !== exp_speed || cycle_cnt !== exp_cnt) begin
                n_errors++;
                $display("FAIL random c=%0d en=%b/%b rstn=%b/%b run=%b/%b spd=%0d/%0d cnt=%h/%h (got/want)",
                         c, cpu_en, exp_en, cpu_rst_n, exp_rst_n, running, exp_running,
                         speed_sel, exp_speed, cycle_cnt, exp_cnt);
            end
            n_checks++;
            if (cpu_en === 1'b1 && cpu_rst_n !== 1'b1) begin
                n_errors++;
                $display("FAIL en_in_reset c=%0d en=%b rstn=%b (want rstn=1)", c, cpu_en, cpu_rst_n);
            end
        end
        {step_p, run_p, speed_p, creset_p, halt} = 5'b00000;
    endtask

    task automatic test_wrap();
        creset_p = 1'b1;
        @(negedge clk);
        creset_p = 1'b0;
        repeat (RST_HOLD + 1) @(negedge clk);
        force dut.r_cycle_cnt = 16'hFFFF;
        #1;
        release dut.r_cycle_cnt;
        #1;
        step_p = 1'b1;
        @(negedge clk);
        step_p = 1'b0;
        n_checks++;
        if (cpu_en !== 1'b1 || cycle_cnt !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL wrap_pre en=%b cnt=%h (want 1 ffff)", cpu_en, cycle_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (cycle_cnt !== 16'h0000) begin
            n_errors++;
            $display("FAIL wrap_cnt cnt=%h (want 0000)", cycle_cnt);
        end
        creset_p = 1'b1;
        @(negedge clk);
        creset_p = 1'b0;
        repeat (RST_HOLD + 1) @(negedge clk);
    endtask

    task automatic test_async_reset();
        run_p = 1'b1;
        @(negedge clk);
        run_p = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (running !== 1'b1) begin
            n_errors++;
            $display("FAIL async_pre running=%b (want 1)", running);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (cpu_en !== 1'b0 || cpu_rst_n !== 1'b0 || running !== 1'b0 ||
            speed_sel !== 2'd0 || cycle_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL async_reset en=%b rstn=%b run=%b spd=%0d cnt=%h (want 0 0 0 0 0000)",
                     cpu_en, cpu_rst_n, running, speed_sel, cycle_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_step();
        test_run_speed();
        test_halt();
        test_priority();
        test_random();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/cpu_step_ctrl.md
# cpu_step_ctrl

Debug execution controller for the single-cycle CPU on the board. It consumes one-cycle key pulses from the push-button debouncers and produces the CPU clock-enable and CPU reset. It supports single-step, free-run at four selectable speeds, pause, and CPU reset, and keeps a cycle counter for the seven-segment debug display.

## Interface
Parameters:
- CNT_W, 27: width of the run-mode period counter.
- DIV_BASE, 1_562_500: run period at speed 0, in clk cycles. At 100 MHz this is 64 Hz.
- RST_HOLD, 16: number of clk cycles cpu_rst_n is held low per CPU reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-low.
- step_p  in  1  one-cycle pulse: execute one CPU cycle.
- run_p  in  1  one-cycle pulse: toggle run/pause.
- speed_p  in  1  one-cycle pulse: advance speed_sel.
- creset_p  in  1  one-cycle pulse: reset the CPU.
- halt  in  1  level from the CPU; high means a halt instruction has retired.
- cpu_en  out  1  one-cycle CPU clock-enable.
- cpu_rst_n  out  1  active-low CPU reset.
- running  out  1  high in RUN state.
- speed_sel  out  2  current speed, 0 (fastest) to 3 (slowest).
- cycle_cnt  out  16  number of cpu_en pulses since the last CPU reset.

## Operation
- States: RST_HOLD_S, PAUSED, RUN.
- Reset values after rst low: state RST_HOLD_S, cpu_en 0, cpu_rst_n 0, running 0, speed_sel 0, cycle_cnt 0, hold counter 0.
- RST_HOLD_S:
  - cpu_rst_n is 0 and cpu_en is 0.
  - The hold counter counts RST_HOLD cycles, then the state goes to PAUSED and cpu_rst_n goes to 1.
  - All key pulses except creset_p are ignored in this state.
- PAUSED:
  - step_p with halt=0 gives exactly one cpu_en pulse.
  - run_p with halt=0 goes to RUN and clears the period counter.
  - If halt=1, step_p and run_p are ignored.
- RUN:
  - Period P = DIV_BASE << (2*speed_sel).
  - The period counter counts 0..P-1. cpu_en is asserted during the cycle after the count P-1 is reached, and the counter restarts at 0.
  - run_p goes to PAUSED with no further cpu_en.
  - halt=1 goes to PAUSED. A cpu_en already registered that cycle still issues.
  - step_p is ignored in RUN.
- creset_p in any state:
  - Goes to RST_HOLD_S, clears the hold counter and cycle_cnt, and drops cpu_en.
  - speed_sel is preserved.
- speed_p in any state except RST_HOLD_S:
  - speed_sel increments and wraps from 3 to 0.
  - In RUN it also clears the period counter.
- Simultaneous pulses are resolved by priority: creset_p > run_p > step_p. speed_p is applied independently unless creset_p is also present.
- cycle_cnt increments on each cpu_en and wraps from 0xFFFF to 0x0000.
- Width rule: the shifted period must fit in CNT_W bits. DIV_BASE<<6 must be ≤ 2^CNT_W; this is checked by an elaboration assertion.

## Timing
- cpu_en is registered.
- Step latency: step_p sampled high at edge k gives cpu_en high during cycle k+1, for exactly one cycle.
- Run: the first cpu_en comes P cycles after the edge that sampled run_p. After that, cpu_en repeats every P cycles.
- Reset release: cpu_rst_n rises RST_HOLD cycles after rst deasserts or after creset_p is sampled.
- running and speed_sel change on the edge that samples the causing pulse.
- cycle_cnt updates on the edge at the end of the cpu_en cycle.
- Never assert cpu_en while cpu_rst_n=0.
- Asynchronous rst mid-RUN forces all reset values immediately.

## Structure
- Shared package cpu_dbg_pkg holds:
  - the state enum (RST_HOLD_S, PAUSED, RUN);
  - the speed encoding constants;
  - the cycle_cnt width (16), which is shared with the display mux.
- Sub-module cpu_tick_gen holds the period counter.
  - Inputs: clk, rst, clear, enable, speed_sel.
  - Output: a one-cycle tick.
  - The FSM, hold counter and cycle_cnt stay in cpu_step_ctrl.

## Test plan
Use DIV_BASE=4 and RST_HOLD=3 on the bench.
- Reset: release rst → cpu_rst_n=0 for 3 cycles, then 1. running=0, cycle_cnt=0, no cpu_en.
- Single step: three step_p pulses 10 cycles apart in PAUSED → three single-cycle cpu_en pulses, each one cycle after its step_p. cycle_cnt=3.
- Run and speed: run_p → cpu_en every 4 cycles. After speed_p → cpu_en every 16 cycles, with the first one 16 cycles after the speed_p. After four speed_p pulses total → speed_sel=0. After run_p again → no cpu_en, running=0.
- Halt: halt=1 during RUN → PAUSED on the next edge with no further cpu_en. step_p and run_p while halt=1 → no cpu_en. creset_p → cpu_rst_n low for 3 cycles and cycle_cnt=0.
- Priority: creset_p, run_p and step_p all in the same cycle → RST_HOLD_S, no cpu_en, running=0. run_p and step_p in the same cycle in PAUSED → RUN and no immediate cpu_en.
- Wrap and async reset: preload 0xFFFF cpu_en pulses (forced start value) plus one step → cycle_cnt=0x0000. rst asserted mid-RUN → all outputs at reset values within the same cycle.
